rtc_bus_arbiter: RTL
====================

// Module: rtc_bus_arbiter
// PURPOSE
//  Owns the RTC multiplexed address/data bus and its control strobes (CS, AD, WR, RD).
//  Arbitrates between the write sequencer (time/date configuration) and the read
//  sequencer (periodic clock/timer refresh), then runs one complete bus cycle per grant:
//  address phase, then data phase.
//  Sits between both sequencers and the top-level tristate pad; replaces ad-hoc strobe muxing.
// PARAMETERS
//  PH_CYC   10   CLK cycles per bus sub-phase (setup/strobe/hold); legal range >= 1
// PORTS
//  CLK       in   1  system clock; all logic on rising edge
//  Reset     in   1  synchronous, active-high reset
//  wr_req    in   1  write request, level; held until wr_done
//  wr_addr   in   8  RTC register address for write
//  wr_data   in   8  data to write
//  rd_req    in   1  read request, level; held until rd_done
//  rd_addr   in   8  RTC register address for read
//  bus_in    in   8  sampled value of the bidirectional bus
//  bus_out   out  8  value driven on the bus when bus_oe=1
//  bus_oe    out  1  tristate enable for the bus pad
//  CSO       out  1  chip select, active-low
//  ADO       out  1  0 = address phase, 1 = data phase / idle
//  WRO       out  1  write strobe, active-low
//  RDO       out  1  read strobe, active-low
//  wr_done   out  1  1-cycle pulse: write transaction complete
//  rd_done   out  1  1-cycle pulse: read complete, rd_data valid
//  rd_data   out  8  last read byte; holds until next read completes
//  busy      out  1  1 in every state except IDLE
// BEHAVIOUR
//  Reset (sync): state=IDLE; CSO=ADO=WRO=RDO=1; bus_oe=0; bus_out=0; rd_data=0;
//   done pulses=0; busy=0; last_grant=READ (so the first contested grant goes to write).
//  Reset mid-transaction: all outputs return to reset values on the next edge;
//   transaction abandoned; no done pulse.
//  States: IDLE, A_SETUP, A_STRB, A_HOLD, D_SETUP, D_STRB, D_HOLD, DONE.
//  IDLE: samples requests on each edge. On grant, latches op, addr, and data; moves to A_SETUP.
//   Only wr_req -> write. Only rd_req -> read.
//   Both asserted -> the op opposite last_grant (strict alternation); last_grant updated on grant.
//  Each A_* / D_* state lasts exactly PH_CYC cycles (phase counter 0..PH_CYC-1, reset on entry).
//  Address phase (A_*): CSO=0, ADO=0, bus_oe=1, bus_out=latched addr.
//   WRO=0 only in A_STRB; RDO=1.
//  Data phase, write: CSO=0, ADO=1, bus_oe=1, bus_out=latched data, WRO=0 only in D_STRB.
//  Data phase, read: CSO=0, ADO=1, bus_oe=0, RDO=0 only in D_STRB.
//   rd_data <= bus_in on the last cycle of D_STRB.
//  DONE (1 cycle): CSO=ADO=WRO=RDO=1, bus_oe=0; the matching done pulse asserted; next state IDLE.
//  Latency: grant edge -> done pulse = 6*PH_CYC+1 cycles.
//   At least one IDLE cycle (CSO=1) separates transactions (bus turnaround).
//  Request changes after grant are ignored until the next IDLE sample.
//   A requester still asserting in the IDLE after its done is treated as a new request.
//  Counter width: $clog2(PH_CYC+1); no wrap beyond PH_CYC-1.
// TESTING (PH_CYC=2)
//  Write only, addr=0x21, data=0x45:
//   ADO=0 and bus_out=0x21 for cycles 1-6; WRO=0 in cycles 3-4.
//   bus_out=0x45 and WRO=0 in cycles 9-10; wr_done=1 in cycle 13.
//  Read only, addr=0x33, bus_in=0x37: bus_oe=0 in cycles 7-12; RDO=0 in cycles 9-10;
//   rd_done=1 in cycle 13 with rd_data=0x37; rd_data holds afterwards.
//  wr_req and rd_req both asserted from reset and held:
//   grants alternate W,R,W,R; each pair of transactions separated by a CSO=1 idle cycle.
//  Reset asserted during D_STRB of a write: next cycle all strobes=1, bus_oe=0;
//   wr_done never pulses; next grant starts cleanly from IDLE.
//  rd_req rises during a write transaction: write completes undisturbed;
//   read is granted in the IDLE cycle after DONE.
//  Each data-phase strobe is exactly PH_CYC cycles; CSO never glitches high mid-transaction
//   (check with PH_CYC=1 and PH_CYC=5).

Source files
------------

// File: rtl/rtc_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter_if
// Bundles the request side (write/read sequencers) and the RTC pad side of the
// bus arbiter into one interface.
//
// Signals
//   wr_req, wr_addr[7:0], wr_data[7:0]  write request (level) and its payload
//   rd_req, rd_addr[7:0]                read request (level) and its address
//   bus_in[7:0]                         sampled value of the bidirectional bus
//   bus_out[7:0], bus_oe                value and tristate enable for the pad
//   CSO, ADO, WRO, RDO                  RTC strobes (CS/WR/RD active-low,
//                                       ADO=0 during the address phase)
//   wr_done, rd_done                    1-cycle completion pulses
//   rd_data[7:0]                        last byte read; held between reads
//   busy                                arbiter is not idle
//
// Modports
//   master : the arbiter itself (drives the bus and the completion signals)
//   slave  : the sequencers / pad wrapper (drive requests, sample results)
// ---------------------------------------------------------------------------
interface rtc_bus_arbiter_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       CSO;
  logic       ADO;
  logic       WRO;
  logic       RDO;
  logic       wr_done;
  logic       rd_done;
  logic [7:0] rd_data;
  logic       busy;

  modport master (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, bus_in,
    output bus_out, bus_oe, CSO, ADO, WRO, RDO,
    output wr_done, rd_done, rd_data, busy
  );

  modport slave (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, bus_in,
    input  bus_out, bus_oe, CSO, ADO, WRO, RDO,
    input  wr_done, rd_done, rd_data, busy
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter
// Owns the RTC multiplexed address/data bus and its strobes. Arbitrates between
// the write sequencer and the read sequencer and runs one complete bus cycle
// per grant: address phase (setup/strobe/hold) then data phase
// (setup/strobe/hold), followed by a one-cycle DONE state that pulses the
// matching completion flag.
//
// Parameters
//   PH_CYC  CLK cycles per bus sub-phase (>= 1)
//
// Ports
//   CLK    in  system clock, rising edge
//   Reset  in  synchronous, active-high reset
//   bus    rtc_bus_arbiter_if.master
//            requests/payload in, bus value/enable and strobes out,
//            wr_done/rd_done pulses, rd_data, busy
//
// All bus-facing outputs are registered: they are decoded from the next state
// and flopped, so the pad sees glitch-free strobes that change exactly on the
// state-transition edge.
// ---------------------------------------------------------------------------
module rtc_bus_arbiter #(
  parameter int PH_CYC = 10
) (
  input  logic                 CLK,
  input  logic                 Reset,
  rtc_bus_arbiter_if.master    bus
);

  localparam int CNT_W = $clog2(PH_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Operation encoding; also used for the last-grant memory.
  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_SETUP = 3'd1,
    A_STRB  = 3'd2,
    A_HOLD  = 3'd3,
    D_SETUP = 3'd4,
    D_STRB  = 3'd5,
    D_HOLD  = 3'd6,
    DONE    = 3'd7
  } state_t;

  // -------------------------------------------------------------------------
  // FSM and transaction context
  // -------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             op_reg, op_next;
  logic [7:0]       addr_reg, addr_next;
  logic [7:0]       data_reg, data_next;
  logic             last_grant_reg, last_grant_next;

  // -------------------------------------------------------------------------
  // Registered outputs
  // -------------------------------------------------------------------------
  logic       cso_reg, cso_next;
  logic       ado_reg, ado_next;
  logic       wro_reg, wro_next;
  logic       rdo_reg, rdo_next;
  logic       oe_reg, oe_next;
  logic [7:0] out_reg, out_next;
  logic       wr_done_reg, wr_done_next;
  logic       rd_done_reg, rd_done_next;
  logic       busy_reg, busy_next;
  logic [7:0] rd_data_reg;

  logic phase_end;
  logic grant_rd;
  logic capture_rd;

  assign phase_end = (cnt_reg == CNT_LAST);

  // The read byte is taken on the final cycle of the read strobe, while RD is
  // still low and the RTC is guaranteed to be driving the bus.
  assign capture_rd = (state_reg == D_STRB) && (op_reg == OP_RD) && phase_end;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      op_reg         <= OP_WR;
      addr_reg       <= '0;
      data_reg       <= '0;
      // Remembering a read as the last grant makes the first contested
      // grant after reset go to the write sequencer.
      last_grant_reg <= OP_RD;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      op_reg         <= op_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    op_next         = op_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    last_grant_next = last_grant_reg;
    grant_rd        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.wr_req || bus.rd_req) begin
          // A lone request wins outright; when both are pending the op that
          // was not granted last time wins (strict alternation).
          grant_rd        = bus.rd_req && (!bus.wr_req || (last_grant_reg == OP_WR));
          op_next         = grant_rd;
          addr_next       = grant_rd ? bus.rd_addr : bus.wr_addr;
          data_next       = bus.wr_data;
          last_grant_next = grant_rd;
          cnt_next        = '0;
          state_next      = A_SETUP;
        end
      end

      A_SETUP, A_STRB, A_HOLD, D_SETUP, D_STRB, D_HOLD: begin
        if (phase_end) begin
          cnt_next = '0;
          case (state_reg)
            A_SETUP: state_next = A_STRB;
            A_STRB:  state_next = A_HOLD;
            A_HOLD:  state_next = D_SETUP;
            D_SETUP: state_next = D_STRB;
            D_STRB:  state_next = D_HOLD;
            default: state_next = DONE;
          endcase
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode, evaluated on the state being entered so the flopped
  // outputs line up with the registered state.
  // -------------------------------------------------------------------------
  always_comb begin
    cso_next     = 1'b1;
    ado_next     = 1'b1;
    wro_next     = 1'b1;
    rdo_next     = 1'b1;
    oe_next      = 1'b0;
    out_next     = '0;
    wr_done_next = 1'b0;
    rd_done_next = 1'b0;
    busy_next    = (state_next != IDLE);

    case (state_next)
      A_SETUP, A_STRB, A_HOLD: begin
        // The address is latched by the RTC on WR in the address phase for
        // both reads and writes.
        cso_next = 1'b0;
        ado_next = 1'b0;
        oe_next  = 1'b1;
        out_next = addr_next;
        wro_next = (state_next != A_STRB);
      end

      D_SETUP, D_STRB, D_HOLD: begin
        cso_next = 1'b0;
        if (op_next == OP_WR) begin
          oe_next  = 1'b1;
          out_next = data_next;
          wro_next = (state_next != D_STRB);
        end else begin
          // Pad released so the RTC can drive the bus.
          rdo_next = (state_next != D_STRB);
        end
      end

      DONE: begin
        wr_done_next = (op_next == OP_WR);
        rd_done_next = (op_next == OP_RD);
      end

      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cso_reg     <= 1'b1;
      ado_reg     <= 1'b1;
      wro_reg     <= 1'b1;
      rdo_reg     <= 1'b1;
      oe_reg      <= 1'b0;
      out_reg     <= '0;
      wr_done_reg <= 1'b0;
      rd_done_reg <= 1'b0;
      busy_reg    <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      cso_reg     <= cso_next;
      ado_reg     <= ado_next;
      wro_reg     <= wro_next;
      rdo_reg     <= rdo_next;
      oe_reg      <= oe_next;
      out_reg     <= out_next;
      wr_done_reg <= wr_done_next;
      rd_done_reg <= rd_done_next;
      busy_reg    <= busy_next;
      if (capture_rd) begin
        rd_data_reg <= bus.bus_in;
      end
    end
  end

  assign bus.CSO     = cso_reg;
  assign bus.ADO     = ado_reg;
  assign bus.WRO     = wro_reg;
  assign bus.RDO     = rdo_reg;
  assign bus.bus_oe  = oe_reg;
  assign bus.bus_out = out_reg;
  assign bus.wr_done = wr_done_reg;
  assign bus.rd_done = rd_done_reg;
  assign bus.rd_data = rd_data_reg;
  assign bus.busy    = busy_reg;

endmodule
